// File: rtl/j1p_pkg.sv
// Shared definitions for the j1p stack CPU: instruction classes, ALU ops,
// field positions, stack-delta codes and fault flag indices.
package j1p_pkg;

  localparam logic [2:0] CLS_JMP  = 3'b000;
  localparam logic [2:0] CLS_BR0  = 3'b001;
  localparam logic [2:0] CLS_CALL = 3'b010;
  localparam logic [2:0] CLS_ALU  = 3'b011;
  localparam int         BIT_LIT  = 15;

  localparam int BIT_R2P = 7;
  localparam int BIT_N2A = 6;
  localparam int BIT_T2R = 5;
  localparam int BIT_T2N = 4;

  localparam logic [1:0] DLT_INC = 2'b01;
  localparam logic [1:0] DLT_DEC = 2'b11;

  localparam int FLT_DOVF = 0;
  localparam int FLT_DUNF = 1;
  localparam int FLT_ROVF = 2;
  localparam int FLT_RUNF = 3;

  typedef enum logic [3:0] {
    OP_T, OP_N, OP_ADD, OP_AND, OP_OR, OP_XOR, OP_INV, OP_EQ,
    OP_SGT, OP_SRA, OP_DEC, OP_R, OP_LD, OP_SHL, OP_DEP, OP_UGT
  } alu_op_e;

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALT} core_state_e;

  typedef struct packed {
    logic push;
    logic pop;
  } dlt_t;

  // Reserved code 2'b10 decodes as no movement.
  function automatic dlt_t dlt_dec(input logic [1:0] d);
    dlt_t r;
    r.push = (d == DLT_INC);
    r.pop  = (d == DLT_DEC);
    return r;
  endfunction

endpackage

// File: rtl/j1p_stack.sv
// Register-array LIFO; updates on the clock when en is high, top/count/ovf/unf are combinational.
// push+pop together replaces the top entry; no internal backpressure, the caller gates en on faults.
module j1p_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 15,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_dat,
  output logic [WIDTH-1:0] top_dat,
  output logic [CNT_W-1:0] count,
  output logic             ovf,
  output logic             unf
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign count = cnt_q;
  assign ovf   = push && !pop && (cnt_q == CNT_W'(DEPTH));
  assign unf   = pop && (cnt_q == '0);

  always_comb begin
    top_dat = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(cnt_q) == i + 1) top_dat = mem_q[i];
    end
  end

  always_comb begin
    mem_d = mem_q;
    cnt_d = cnt_q;
    if (en) begin
      if (push && pop) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(cnt_q) == i + 1) mem_d[i] = push_dat;
        end
      end else if (push) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (int'(cnt_q) == i) mem_d[i] = push_dat;
        end
        cnt_d = cnt_q + 1'b1;
      end else if (pop) begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      cnt_q <= cnt_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/j1p_core.sv
// J1-compatible stack CPU, one instruction per cycle; code_addr is the next pc (sync ROM).
// Loads hold mem_rd and freeze all state until mem_ready; a stack fault halts until reset.
module j1p_core
  import j1p_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DDEPTH = 15,
  parameter int RDEPTH = 17,
  parameter int CNT_W  = $clog2(RDEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  output logic [12:0]      code_addr,
  input  logic [15:0]      insn,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] dout,
  output logic             mem_wr,
  output logic             mem_rd,
  input  logic             mem_ready,
  input  logic [WIDTH-1:0] din,
  output logic [3:0]       fault
);

  core_state_e      state_q, state_d;
  logic [12:0]      pc_q, pc_d;
  logic [WIDTH-1:0] t_q, t_d;
  logic             t_vld_q, t_vld_d;
  logic [3:0]       fault_q, fault_d;

  logic [WIDTH-1:0] n_w, r_w, rs_in, alu_t;
  logic [CNT_W-1:0] dcount, rcount;
  logic             d_ovf, d_unf, r_ovf, r_unf;
  logic             ds_push_req, ds_push, ds_pop, rs_push, rs_pop;
  logic             exec, is_lit, is_alu, is_load, stall, trip, commit;
  logic [3:0]       flags;
  logic [12:0]      ret_addr;
  dlt_t             dd, rd;

  assign exec     = (state_q == ST_RUN);
  assign is_lit   = insn[BIT_LIT];
  assign is_alu   = (insn[15:13] == CLS_ALU);
  assign is_load  = is_alu && (insn[12:8] == 5'd12);
  assign dd       = dlt_dec(insn[1:0]);
  assign rd       = dlt_dec(insn[3:2]);
  assign ret_addr = pc_q + 13'd1;

  // T starts empty after reset, so the first push only fills T.
  always_comb begin
    ds_push_req = 1'b0;
    ds_pop      = 1'b0;
    rs_push     = 1'b0;
    rs_pop      = 1'b0;
    if (is_lit) begin
      ds_push_req = 1'b1;
    end else if (insn[15:13] == CLS_BR0) begin
      ds_pop = 1'b1;
    end else if (insn[15:13] == CLS_CALL) begin
      rs_push = 1'b1;
    end else if (is_alu) begin
      ds_push_req = dd.push | (insn[BIT_T2N] & ~dd.pop);
      ds_pop      = dd.pop  | (insn[BIT_T2N] & ~dd.push);
      rs_push     = rd.push;
      rs_pop      = rd.pop;
    end
    ds_push = ds_push_req && (t_vld_q || ds_pop);
  end

  assign rs_in = (is_alu && insn[BIT_T2R]) ? t_q
                                           : {{(WIDTH-14){1'b0}}, ret_addr, 1'b0};

  always_comb begin
    flags           = '0;
    flags[FLT_DOVF] = d_ovf;
    flags[FLT_DUNF] = d_unf;
    flags[FLT_ROVF] = r_ovf;
    flags[FLT_RUNF] = r_unf;
  end

  assign trip   = exec && (|flags);
  assign stall  = exec && is_load && !mem_ready;
  assign commit = exec && !trip && !stall;

  j1p_stack #(.WIDTH(WIDTH), .DEPTH(DDEPTH), .CNT_W(CNT_W)) u_dstack (
    .clk(clk), .rst_n(reset_n), .en(commit), .push(ds_push), .pop(ds_pop),
    .push_dat(t_q), .top_dat(n_w), .count(dcount), .ovf(d_ovf), .unf(d_unf)
  );

  j1p_stack #(.WIDTH(WIDTH), .DEPTH(RDEPTH), .CNT_W(CNT_W)) u_rstack (
    .clk(clk), .rst_n(reset_n), .en(commit), .push(rs_push), .pop(rs_pop),
    .push_dat(rs_in), .top_dat(r_w), .count(rcount), .ovf(r_ovf), .unf(r_unf)
  );

  always_comb begin
    alu_t = t_q;
    if (!insn[12]) begin
      case (alu_op_e'(insn[11:8]))
        OP_T:    alu_t = t_q;
        OP_N:    alu_t = n_w;
        OP_ADD:  alu_t = t_q + n_w;
        OP_AND:  alu_t = t_q & n_w;
        OP_OR:   alu_t = t_q | n_w;
        OP_XOR:  alu_t = t_q ^ n_w;
        OP_INV:  alu_t = ~t_q;
        OP_EQ:   alu_t = {WIDTH{n_w == t_q}};
        OP_SGT:  alu_t = {WIDTH{$signed(t_q) > $signed(n_w)}};
        OP_SRA:  alu_t = {t_q[WIDTH-1], t_q[WIDTH-1:1]};
        OP_DEC:  alu_t = t_q - WIDTH'(1);
        OP_R:    alu_t = r_w;
        OP_LD:   alu_t = din;
        OP_SHL:  alu_t = {t_q[WIDTH-2:0], 1'b0};
        OP_DEP:  alu_t = WIDTH'(dcount);
        OP_UGT:  alu_t = {WIDTH{t_q > n_w}};
        default: alu_t = t_q;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    t_d     = t_q;
    t_vld_d = t_vld_q;
    fault_d = fault_q | (trip ? flags : 4'b0);
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = '0;
      end
      ST_RUN: begin
        if (trip) begin
          state_d = ST_HALT;
        end else if (commit) begin
          pc_d = ret_addr;
          if (ds_push_req) t_vld_d = 1'b1;
          if (is_lit) begin
            t_d = {{(WIDTH-15){1'b0}}, insn[14:0]};
          end else begin
            case (insn[15:13])
              CLS_JMP, CLS_CALL: pc_d = insn[12:0];
              CLS_BR0: begin
                if (t_q == '0) pc_d = insn[12:0];
                t_d = n_w;
              end
              default: begin
                t_d = alu_t;
                if (insn[BIT_R2P]) pc_d = r_w[13:1];
              end
            endcase
          end
        end
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_BOOT;
      pc_q    <= '0;
      t_q     <= '0;
      t_vld_q <= 1'b0;
      fault_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      t_q     <= t_d;
      t_vld_q <= t_vld_d;
      fault_q <= fault_d;
    end
  end

  assign code_addr = pc_d;
  assign mem_addr  = t_q;
  assign dout      = n_w;
  assign mem_wr    = commit && is_alu && insn[BIT_N2A];
  assign mem_rd    = exec && is_load && !trip;
  assign fault     = fault_q;

  a_cnt_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (dcount <= CNT_W'(DDEPTH)) && (rcount <= CNT_W'(RDEPTH)));

endmodule

// File: tb/tb_j1p_core.sv
// Directed bench for j1p_core (WIDTH=32, DDEPTH=4) with a synchronous ROM model.
module tb_j1p_core;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [12:0] code_addr;
  logic [15:0] insn = 16'h6000;
  logic [31:0] mem_addr, dout, din = '0;
  logic        mem_wr, mem_rd, mem_ready = 1'b1;
  logic [3:0]  fault;
  logic [15:0] rom [8192];
  int          n_chk = 0;
  int          n_fail = 0;

  j1p_core #(.WIDTH(32), .DDEPTH(4), .RDEPTH(17)) dut (
    .clk(clk), .reset_n(reset_n), .code_addr(code_addr), .insn(insn),
    .mem_addr(mem_addr), .dout(dout), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_ready(mem_ready), .din(din), .fault(fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) insn <= rom[code_addr];

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 8192; i++) rom[i] = 16'h6000;
  endtask

  // Leaves the bench in the reboot cycle, 1 time unit after release.
  task automatic restart();
    reset_n = 1'b0;
    mem_ready = 1'b1;
    din = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_rom();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++; if (code_addr !== 13'h0) begin n_fail++; $display("FAIL rst_code_addr got %h want 0", code_addr); end
    n_chk++; if ({mem_wr, mem_rd} !== 2'b00) begin n_fail++; $display("FAIL rst_strobes got %b want 00", {mem_wr, mem_rd}); end
    n_chk++; if (fault !== 4'h0) begin n_fail++; $display("FAIL rst_fault got %h want 0", fault); end
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_t got %h want 0", mem_addr); end
    reset_n = 1'b1;
    #1;
    n_chk++; if (code_addr !== 13'h0) begin n_fail++; $display("FAIL reboot_code_addr got %h want 0", code_addr); end
    for (int k = 1; k <= 3; k++) begin
      step();
      n_chk++; if (code_addr !== 13'(k)) begin n_fail++; $display("FAIL seq_code_addr got %h want %h", code_addr, 13'(k)); end
      n_chk++; if ({fault, mem_wr} !== 5'b0) begin n_fail++; $display("FAIL seq_quiet got %b want 0", {fault, mem_wr}); end
    end
  endtask

  task automatic test_arith();
    clear_rom();
    rom[0] = 16'hFFFF; rom[1] = 16'h8001; rom[2] = 16'h6203; rom[3] = 16'h6900;
    rom[4] = 16'h6E01; rom[5] = 16'h6A00; rom[6] = 16'h6F00; rom[7] = 16'h6800;
    restart();
    repeat (3) step();
    n_chk++; if (dout !== 32'h7FFF) begin n_fail++; $display("FAIL arith_n got %h want 00007fff", dout); end
    step();
    n_chk++; if (mem_addr !== 32'h8000) begin n_fail++; $display("FAIL arith_add got %h want 00008000", mem_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h4000) begin n_fail++; $display("FAIL arith_sra got %h want 00004000", mem_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL arith_depth got %h want 0", mem_addr); end
    n_chk++; if (dout !== 32'h4000) begin n_fail++; $display("FAIL arith_dup_n got %h want 00004000", dout); end
    step();
    n_chk++; if (mem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL arith_dec got %h want ffffffff", mem_addr); end
    step();
    n_chk++; if (mem_addr !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL arith_ugt got %h want ffffffff", mem_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL arith_sgt got %h want 0", mem_addr); end
  endtask

  task automatic test_load();
    int rd_cyc = 0;
    clear_rom();
    rom[0] = 16'h9234; rom[1] = 16'h6C00; rom[3] = 16'h6C00; rom[5] = 16'h6C00;
    restart();
    step();
    mem_ready = 1'b0;
    step();
    for (int k = 0; k < 3; k++) begin
      if (mem_rd) rd_cyc++;
      n_chk++; if (code_addr !== 13'h1) begin n_fail++; $display("FAIL ld_wait_pc got %h want 001", code_addr); end
      n_chk++; if (mem_addr !== 32'h1234 || mem_wr !== 1'b0) begin n_fail++; $display("FAIL ld_wait_state got %h/%b want 00001234/0", mem_addr, mem_wr); end
      step();
    end
    mem_ready = 1'b1;
    din = 32'hA5A5;
    #1;
    if (mem_rd) rd_cyc++;
    n_chk++; if (code_addr !== 13'h2) begin n_fail++; $display("FAIL ld_done_pc got %h want 002", code_addr); end
    step();
    n_chk++; if (mem_addr !== 32'hA5A5) begin n_fail++; $display("FAIL ld_data got %h want 0000a5a5", mem_addr); end
    n_chk++; if (rd_cyc !== 4) begin n_fail++; $display("FAIL ld_rd_cycles got %0d want 4", rd_cyc); end
    step();
    din = 32'h5A5A;
    #1;
    n_chk++; if (mem_rd !== 1'b1 || code_addr !== 13'h4) begin n_fail++; $display("FAIL ld0_issue got %b/%h want 1/004", mem_rd, code_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h5A5A || mem_rd !== 1'b0) begin n_fail++; $display("FAIL ld0_data got %h/%b want 00005a5a/0", mem_addr, mem_rd); end
    mem_ready = 1'b0;
    step();
    n_chk++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL ldr_rd got %b want 1", mem_rd); end
    #2 reset_n = 1'b0;
    #1;
    n_chk++; if (mem_rd !== 1'b0 || code_addr !== 13'h0) begin n_fail++; $display("FAIL ldr_abort got %b/%h want 0/000", mem_rd, code_addr); end
  endtask

  task automatic test_call_ret();
    clear_rom();
    rom[0] = 16'h0010; rom[16'h10] = 16'h4100; rom[16'h11] = 16'h608C;
    rom[16'h100] = 16'h6B00; rom[16'h101] = 16'h608C;
    restart();
    step();
    n_chk++; if (code_addr !== 13'h010) begin n_fail++; $display("FAIL jmp_target got %h want 010", code_addr); end
    step();
    n_chk++; if (code_addr !== 13'h100) begin n_fail++; $display("FAIL call_target got %h want 100", code_addr); end
    step();
    step();
    n_chk++; if (mem_addr !== 32'h22) begin n_fail++; $display("FAIL call_r got %h want 00000022", mem_addr); end
    n_chk++; if (code_addr !== 13'h011) begin n_fail++; $display("FAIL ret_target got %h want 011", code_addr); end
    step();
    n_chk++; if (code_addr !== 13'h011) begin n_fail++; $display("FAIL runf_freeze got %h want 011", code_addr); end
    step();
    n_chk++; if (fault !== 4'b1000) begin n_fail++; $display("FAIL runf_flag got %b want 1000", fault); end
    n_chk++; if (code_addr !== 13'h011 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL runf_halt got %h/%b want 011/0", code_addr, mem_rd); end
  endtask

  task automatic test_dstack_fault();
    clear_rom();
    for (int i = 0; i < 6; i++) rom[i] = 16'h8001 + 16'(i);
    restart();
    repeat (6) step();
    n_chk++; if (code_addr !== 13'h5 || mem_addr !== 32'h5) begin n_fail++; $display("FAIL ovf_cycle got %h/%h want 005/00000005", code_addr, mem_addr); end
    step();
    n_chk++; if (fault !== 4'b0001) begin n_fail++; $display("FAIL ovf_flag got %b want 0001", fault); end
    n_chk++; if (mem_addr !== 32'h5) begin n_fail++; $display("FAIL ovf_t got %h want 00000005", mem_addr); end
    step();
    n_chk++; if (code_addr !== 13'h5 || fault !== 4'b0001) begin n_fail++; $display("FAIL ovf_halt got %h/%b want 005/0001", code_addr, fault); end
    reset_n = 1'b0;
    #1;
    n_chk++; if (fault !== 4'h0) begin n_fail++; $display("FAIL ovf_clear got %b want 0000", fault); end
  endtask

  task automatic test_branch();
    clear_rom();
    rom[0] = 16'h8000; rom[1] = 16'h8005; rom[2] = 16'h8000; rom[3] = 16'h2020;
    rom[16'h20] = 16'h2040; rom[16'h21] = 16'h6040;
    restart();
    repeat (4) step();
    n_chk++; if (code_addr !== 13'h020) begin n_fail++; $display("FAIL br_taken got %h want 020", code_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h5) begin n_fail++; $display("FAIL br_pop1 got %h want 00000005", mem_addr); end
    n_chk++; if (code_addr !== 13'h021) begin n_fail++; $display("FAIL br_not_taken got %h want 021", code_addr); end
    step();
    n_chk++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL br_pop2 got %h want 0", mem_addr); end
    n_chk++; if (mem_wr !== 1'b1) begin n_fail++; $display("FAIL st_strobe got %b want 1", mem_wr); end
    step();
    n_chk++; if (mem_wr !== 1'b0 || fault !== 4'h0) begin n_fail++; $display("FAIL st_one_cycle got %b/%b want 0/0000", mem_wr, fault); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_load();
    test_call_ret();
    test_dstack_fault();
    test_branch();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
